// File: rtl/car_pkg.sv
// rtl/car_pkg.sv - shared move codes, motor commands, FSM states and move reversal
package car_pkg;

   localparam logic [1:0] MOVE_NONE  = 2'b00;
   localparam logic [1:0] MOVE_FWD   = 2'b01;
   localparam logic [1:0] MOVE_LEFT  = 2'b10;
   localparam logic [1:0] MOVE_RIGHT = 2'b11;

   localparam logic [2:0] CMD_STOP   = 3'd0;
   localparam logic [2:0] CMD_FWD    = 3'd1;
   localparam logic [2:0] CMD_BACK   = 3'd2;
   localparam logic [2:0] CMD_LEFT   = 3'd3;
   localparam logic [2:0] CMD_RIGHT  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_CAPT   = 3'd2,
      ST_DRIVE  = 3'd3,
      ST_SETTLE = 3'd4,
      ST_FIN    = 3'd5
   } bt_state_t;

   // Undoing a recorded move: forward is undone by reversing, a left turn by
   // turning right and a right turn by turning left.
   function automatic logic [2:0] reverse_move(input logic [1:0] move);
      logic [2:0] cmd;
      case (move)
         MOVE_FWD:   cmd = CMD_BACK;
         MOVE_LEFT:  cmd = CMD_RIGHT;
         MOVE_RIGHT: cmd = CMD_LEFT;
         default:    cmd = CMD_STOP;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/hold_timer.sv
// rtl/hold_timer.sv - loadable down-counter with zero flag for timed motor holds
module hold_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   // Load takes priority; otherwise count down while enabled, stopping at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/backtrack_ctrl.sv
// rtl/backtrack_ctrl.sv - pops recorded moves and drives the reverse motor command for each
module backtrack_ctrl
   import car_pkg::*;
#(
   parameter int MOVE_CYCLES = 1000,
   parameter int MAX_MOVES   = 49,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   output logic       pop,
   input  logic [1:0] pop_val,
   output logic       stack_en,
   output logic [2:0] motor_cmd,
   output logic       busy,
   output logic       done,
   output logic [5:0] moves_undone
);

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MOVE_CYCLES - 1);
   localparam logic [5:0]       MOVE_LIM  = 6'(MAX_MOVES);

   bt_state_t state;
   bt_state_t next_state;

   logic start_q;
   logic start_edge;
   logic timer_load;
   logic timer_en;
   logic timer_zero;
   logic move_inc;
   logic clear_moves;

   assign start_edge = start & ~start_q;
   assign stack_en   = busy;

   hold_timer #(
      .CNT_W (CNT_W)
   ) u_hold_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .en       (timer_en),
      .load_val (HOLD_LOAD),
      .zero     (timer_zero)
   );

   // Track start so only a fresh rising edge can launch a run; always sampled,
   // so an edge seen while busy or together with abort is consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= 1'b0;
      end else begin
         start_q <= start;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic plus hold-timer and move-counter controls; abort overrides all.
   always_comb begin
      next_state  = state;
      timer_load  = 1'b0;
      timer_en    = 1'b0;
      move_inc    = 1'b0;
      clear_moves = 1'b0;
      if (abort) begin
         next_state = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_edge) begin
                  clear_moves = 1'b1;
                  next_state  = ST_REQ;
               end
            end
            ST_REQ: begin
               next_state = ST_CAPT;
            end
            ST_CAPT: begin
               if (pop_val == MOVE_NONE) begin
                  next_state = ST_FIN;
               end else begin
                  timer_load = 1'b1;
                  next_state = ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               if (timer_zero) begin
                  move_inc   = 1'b1;
                  next_state = ST_SETTLE;
               end else begin
                  timer_en = 1'b1;
               end
            end
            ST_SETTLE: begin
               if (moves_undone >= MOVE_LIM) begin
                  next_state = ST_FIN;
               end else begin
                  next_state = ST_REQ;
               end
            end
            ST_FIN: begin
               next_state = ST_IDLE;
            end
            default: begin
               next_state = ST_IDLE;
            end
         endcase
      end
   end

   // Registered outputs decoded from the upcoming state so each is glitch-free
   // and aligned with the state it belongs to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pop       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         motor_cmd <= CMD_STOP;
      end else begin
         pop  <= (next_state == ST_REQ);
         busy <= (next_state != ST_IDLE);
         done <= (next_state == ST_FIN);
         if (next_state == ST_DRIVE) begin
            if (state == ST_CAPT) begin
               motor_cmd <= reverse_move(pop_val);
            end
         end else begin
            motor_cmd <= CMD_STOP;
         end
      end
   end

   // Count completed reversals; cleared when a run launches, saturating at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         moves_undone <= 6'd0;
      end else if (clear_moves) begin
         moves_undone <= 6'd0;
      end else if (move_inc && (moves_undone < MOVE_LIM)) begin
         moves_undone <= moves_undone + 6'd1;
      end
   end

endmodule

// File: doc/backtrack_ctrl.md
Name: backtrack_ctrl

Overview:
- Downstream consumer of the 2-bit move stack.
- On start, pops recorded moves one at a time and drives the reverse motor command for each.
- Each reverse command is held for a fixed number of cycles; the block stops when the stack yields the empty code (2'b00) or the move limit is reached.
- Sits between the move stack and the motor driver in the car datapath.

Parameters:
- MOVE_CYCLES, 1000, cycles each reverse command is held (bench uses 4).
- MAX_MOVES, 49, hard limit on pops per run; equals stack depth.
- CNT_W, 16, width of the hold counter; must hold MOVE_CYCLES-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; run begins on rising edge while IDLE
- abort  in  1  synchronous; forces IDLE from any state
- pop  out  1  pop request to stack, registered
- pop_val  in  2  value returned by stack; 00 = empty, 01 = forward, 10 = left, 11 = right
- stack_en  out  1  stack enable, equals busy
- motor_cmd  out  3  0 stop, 1 forward, 2 backward, 3 turn-left, 4 turn-right
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on completion
- moves_undone  out  6  count of moves reversed this run

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; pop=0, motor_cmd=0, busy=0, done=0, moves_undone=0, hold counter=0, start edge register=0.
- start edge detect: start_q registered; edge = start & ~start_q. Edges in non-IDLE states are ignored.
- States: IDLE, REQ, CAPT, DRIVE, SETTLE, FIN.
- IDLE: on start edge, clear moves_undone and go to REQ.
- REQ: pop=1 for exactly this one cycle; next state is CAPT.
- CAPT: pop=0. pop_val is valid this cycle, because the stack registers it on the edge ending REQ.
  - If pop_val==00, go to FIN.
  - Otherwise latch the reversed command and go to DRIVE.
  - Mapping: 01→2, 10→4, 11→3.
- DRIVE:
  - motor_cmd = latched command, registered output valid from the first DRIVE cycle.
  - Counter loads MOVE_CYCLES-1 on entry and decrements; at 0, moves_undone increments and the state goes to SETTLE.
  - DRIVE lasts exactly MOVE_CYCLES cycles.
- SETTLE: motor_cmd=0 for one cycle.
  - If moves_undone==MAX_MOVES, go to FIN; else go to REQ.
  - SETTLE guarantees pop is low for at least 3 cycles between requests, so the stack's edge detector re-arms.
- FIN: done=1 for one cycle, motor_cmd=0; next state IDLE.
- abort: highest priority after reset.
  - Next cycle: state IDLE, pop=0, motor_cmd=0, done=0; moves_undone is held.
  - A pop already issued in REQ is not retried.
- abort and start edge in the same cycle: abort wins, and the start edge is consumed.
- Empty on the first pop: sequence is REQ, CAPT, FIN; done pulses with moves_undone=0.
- Loop latency: each move costs 1 (REQ) + 1 (CAPT) + MOVE_CYCLES (DRIVE) + 1 (SETTLE) cycles.
- moves_undone saturates at MAX_MOVES and never wraps.
- pop_val is ignored outside CAPT.

Decomposition:
- Shared package car_pkg:
  - move codes MOVE_NONE/FWD/LEFT/RIGHT (2-bit);
  - motor command constants CMD_STOP/FWD/BACK/LEFT/RIGHT (3-bit);
  - state enum typedef;
  - function reverse_move(move) → cmd.
- Sub-module: hold_timer (load, count-down, zero flag, CNT_W wide), reused later by the forward path driver.
- Everything else lives in one FSM module.

Test Plan:
- Reset mid-DRIVE: assert rst_n=0 during the 2nd DRIVE cycle → all outputs 0 immediately (asynchronous); FSM in IDLE after release.
- Three-move unwind: stack model holds [01,10,11] top=11, MOVE_CYCLES=4, start pulse →
  - pop pulses spaced 7 cycles apart;
  - motor_cmd sequence 3,3,3,3,0 then 4×4,0 then 2×4,0;
  - 4th pop returns 00 → done pulse with moves_undone=3; busy drops on the cycle after done.
- Empty stack: pop_val 00 on the first CAPT → done exactly 3 cycles after the start edge; motor_cmd stays 0; moves_undone=0.
- Abort in DRIVE: abort asserted on the 2nd DRIVE cycle of move 2 → next cycle motor_cmd=0, busy=0, pop=0, no done pulse; moves_undone=1.
- Limit: stack model returning 01 forever, MAX_MOVES=5 → exactly 5 pops, 5 backward holds, done with moves_undone=5.
- start held high through completion and start re-pulsed while busy → no second run; a new rising edge after IDLE starts a fresh run and clears moves_undone to 0.
